// File: rtl/rat_navigator_pkg.sv
// -----------------------------------------------------------------------------
// rat_navigator_pkg
// Shared definitions for the depth-first maze-solving controller: maze size,
// direction encoding, FSM state enum and the neighbour-step helper.
// No ports (package).
// -----------------------------------------------------------------------------
package rat_navigator_pkg;

    localparam int MAZE_DIM = 16;
    localparam int COORD_W  = $clog2(MAZE_DIM);
    localparam int SP_W     = 9;

    typedef logic [1:0] dir_t;

    localparam dir_t DIR_R = 2'b00;  // X+1
    localparam dir_t DIR_D = 2'b01;  // Y+1
    localparam dir_t DIR_L = 2'b10;  // X-1
    localparam dir_t DIR_U = 2'b11;  // Y-1

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_INIT,
        ST_PROBE,
        ST_MOVE,
        ST_POP,
        ST_REPLAY,
        ST_DONE,
        ST_FAIL
    } state_t;

    // Coordinates widened by one bit: bit COORD_W set means the step left
    // the maze (15+1 or 0-1), so out-of-bounds is detected, never wrapped.
    typedef struct packed {
        logic [COORD_W:0] x;
        logic [COORD_W:0] y;
    } coord_ext_t;

    function automatic coord_ext_t step(input logic [COORD_W-1:0] x,
                                        input logic [COORD_W-1:0] y,
                                        input dir_t               dir);
        coord_ext_t c;
        c.x = {1'b0, x};
        c.y = {1'b0, y};
        case (dir)
            DIR_R:   c.x = c.x + 1'b1;
            DIR_D:   c.y = c.y + 1'b1;
            DIR_L:   c.x = c.x - 1'b1;
            default: c.y = c.y - 1'b1;
        endcase
        return c;
    endfunction

    // R<->L and D<->U differ only in the upper bit.
    function automatic dir_t opposite(input dir_t dir);
        return dir ^ 2'b10;
    endfunction

endpackage

// File: rtl/rat_navigator_if.sv
// -----------------------------------------------------------------------------
// rat_navigator_if
// Groups the maze-memory port (X/Y/RD/WR/Din/Dout) and the path stream
// (move_valid/move_dir) of the navigator.
//   master : navigator side (drives address, strobes, write data, path stream)
//   slave  : memory / consumer side (drives Dout)
// -----------------------------------------------------------------------------
interface rat_navigator_if;
    import rat_navigator_pkg::*;

    logic [COORD_W-1:0] X;
    logic [COORD_W-1:0] Y;
    logic               RD;
    logic               WR;
    logic               Din;
    logic               Dout;
    logic               move_valid;
    dir_t               move_dir;

    modport master (
        output X, Y, RD, WR, Din, move_valid, move_dir,
        input  Dout
    );

    modport slave (
        input  X, Y, RD, WR, Din, move_valid, move_dir,
        output Dout
    );

endinterface

// File: rtl/rat_navigator_path_stack.sv
// -----------------------------------------------------------------------------
// rat_navigator_path_stack
// DEPTH x 2-bit direction stack with push/pop and an independent indexed read
// port used to stream the path bottom-to-top.
//   clk, rst   : clock, asynchronous active-low reset (clears sp only)
//   clear      : synchronous empty (sp <= 0)
//   push, push_dir : write push_dir at sp, sp+1
//   pop        : sp-1
//   top_dir    : entry at sp-1
//   sp         : current stack pointer
//   rd_idx, rd_dir : random-access read of entry rd_idx
// -----------------------------------------------------------------------------
module rat_navigator_path_stack
    import rat_navigator_pkg::*;
#(
    parameter int DEPTH = 256
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clear,
    input  logic            push,
    input  dir_t            push_dir,
    input  logic            pop,
    output dir_t            top_dir,
    output logic [SP_W-1:0] sp,
    input  logic [SP_W-1:0] rd_idx,
    output dir_t            rd_dir
);

    localparam int IDX_W = $clog2(DEPTH);

    dir_t            mem [DEPTH];
    logic [SP_W-1:0] sp_q;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sp_q <= '0;
        end else if (clear) begin
            sp_q <= '0;
        end else if (push) begin
            sp_q <= sp_q + SP_W'(1);
        end else if (pop) begin
            sp_q <= sp_q - SP_W'(1);
        end
    end

    // NOTE: the storage array has no reset; entries at or above sp are never
    // read, so clearing them would only cost a reset tree on every bit.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[IDX_W'(sp_q)] <= push_dir;
        end
    end

    assign sp      = sp_q;
    assign top_dir = mem[IDX_W'(sp_q - SP_W'(1))];
    assign rd_dir  = (rd_idx < SP_W'(DEPTH)) ? mem[IDX_W'(rd_idx)] : DIR_R;

    // Every push enters a fresh cell, so a full stack cannot be pushed.
    assert property (@(posedge clk) disable iff (!rst)
                     !(push && (sp_q >= SP_W'(DEPTH))));

endmodule

// File: rtl/rat_navigator.sv
// -----------------------------------------------------------------------------
// rat_navigator
// Depth-first maze solver for a 16x16 one-bit maze memory. On start it walks
// from (0,0) to (GOAL_X,GOAL_Y), marks each entered cell visited (writes 1),
// backtracks on dead ends and then streams the recorded moves, one per cycle.
//   clk, rst   : clock, asynchronous active-low reset
//   start      : one-cycle solve request (honoured in IDLE/DONE/FAIL only)
//   bus        : maze memory port + path stream (master side)
//   busy       : solve or replay in progress
//   done, fail : result flags, held until the next start
//   path_len   : number of moves in the found path
// -----------------------------------------------------------------------------
module rat_navigator
    import rat_navigator_pkg::*;
#(
    parameter int GOAL_X = 15,
    parameter int GOAL_Y = 15,
    parameter int DEPTH  = 256
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    rat_navigator_if.master bus,
    output logic            busy,
    output logic            done,
    output logic            fail,
    output logic [SP_W-1:0] path_len
);

    localparam bit START_IS_GOAL = (GOAL_X == 0) && (GOAL_Y == 0);

    state_t             state_q, state_d;
    logic [COORD_W-1:0] pos_x_q, pos_y_q;
    logic [COORD_W-1:0] addr_x_q, addr_y_q;
    dir_t               d_q;
    logic [SP_W-1:0]    path_len_q;
    logic [SP_W-1:0]    rep_idx_q;

    coord_ext_t         nb, back;
    logic               nb_oob, nb_free, nb_is_goal;
    logic               idle_like, start_accept, last_replay;
    logic [SP_W-1:0]    sp;
    dir_t               top_dir, rd_dir;

    logic [COORD_W-1:0] x_out, y_out;
    logic               rd_out, wr_out, valid_out;
    dir_t               dir_out;

    // ---------------------------------------------------------------- datapath
    assign nb         = step(pos_x_q, pos_y_q, d_q);
    assign back       = step(pos_x_q, pos_y_q, opposite(top_dir));
    assign nb_oob     = nb.x[COORD_W] | nb.y[COORD_W];
    // Dout is only meaningful while RD=1, i.e. for an in-bounds neighbour.
    assign nb_free    = !nb_oob && !bus.Dout;
    assign nb_is_goal = (nb.x == (COORD_W + 1)'(GOAL_X)) && (nb.y == (COORD_W + 1)'(GOAL_Y));

    assign idle_like    = (state_q == ST_IDLE) || (state_q == ST_DONE) || (state_q == ST_FAIL);
    assign start_accept = idle_like && start;
    assign last_replay  = (path_len_q == '0) || (rep_idx_q == path_len_q - SP_W'(1));

    rat_navigator_path_stack #(.DEPTH(DEPTH)) u_path_stack (
        .clk      (clk),
        .rst      (rst),
        .clear    (start_accept),
        .push     (state_q == ST_MOVE),
        .push_dir (d_q),
        .pop      (state_q == ST_POP),
        .top_dir  (top_dir),
        .sp       (sp),
        .rd_idx   (rep_idx_q),
        .rd_dir   (rd_dir)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pos_x_q    <= '0;
            pos_y_q    <= '0;
            d_q        <= DIR_R;
            path_len_q <= '0;
            rep_idx_q  <= '0;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE, ST_FAIL: begin
                    if (start) begin
                        pos_x_q    <= '0;
                        pos_y_q    <= '0;
                        d_q        <= DIR_R;
                        path_len_q <= '0;
                        rep_idx_q  <= '0;
                    end
                end
                ST_PROBE: begin
                    // d saturates at 3; POP or FAIL follows and resets it.
                    if (!nb_free && (d_q != DIR_U)) begin
                        d_q <= d_q + 2'd1;
                    end
                end
                ST_MOVE: begin
                    pos_x_q <= nb.x[COORD_W-1:0];
                    pos_y_q <= nb.y[COORD_W-1:0];
                    d_q     <= DIR_R;
                    if (nb_is_goal) begin
                        path_len_q <= sp + SP_W'(1);  // includes this push
                    end
                end
                ST_POP: begin
                    pos_x_q <= back.x[COORD_W-1:0];
                    pos_y_q <= back.y[COORD_W-1:0];
                    d_q     <= DIR_R;
                end
                ST_REPLAY: begin
                    rep_idx_q <= rep_idx_q + SP_W'(1);
                end
                default: ;
            endcase
        end
    end

    // Backtracking retraces a step already taken, so it stays inside the maze.
    assert property (@(posedge clk) disable iff (!rst)
                     (state_q == ST_POP) |-> !(back.x[COORD_W] || back.y[COORD_W]));

    // Last driven address, so X/Y hold their value outside memory cycles.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr_x_q <= '0;
            addr_y_q <= '0;
        end else begin
            addr_x_q <= x_out;
            addr_y_q <= y_out;
        end
    end

    // ------------------------------------------------------------------- FSM
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: every combinational output is given a default before the case so
    // no path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE, ST_DONE, ST_FAIL: begin
                if (start) state_d = ST_INIT;
            end
            ST_INIT: begin
                state_d = START_IS_GOAL ? ST_REPLAY : ST_PROBE;
            end
            ST_PROBE: begin
                if (nb_free) begin
                    state_d = ST_MOVE;
                end else if (d_q == DIR_U) begin
                    state_d = (sp == '0) ? ST_FAIL : ST_POP;
                end
            end
            ST_MOVE: begin
                state_d = nb_is_goal ? ST_REPLAY : ST_PROBE;
            end
            ST_POP: begin
                state_d = ST_PROBE;
            end
            ST_REPLAY: begin
                if (last_replay) state_d = ST_DONE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        x_out     = addr_x_q;
        y_out     = addr_y_q;
        rd_out    = 1'b0;
        wr_out    = 1'b0;
        valid_out = 1'b0;
        dir_out   = DIR_R;
        case (state_q)
            ST_INIT: begin
                wr_out = 1'b1;
                x_out  = pos_x_q;
                y_out  = pos_y_q;
            end
            ST_PROBE: begin
                if (!nb_oob) begin
                    rd_out = 1'b1;
                    x_out  = nb.x[COORD_W-1:0];
                    y_out  = nb.y[COORD_W-1:0];
                end
            end
            ST_MOVE: begin
                wr_out = 1'b1;
                x_out  = nb.x[COORD_W-1:0];
                y_out  = nb.y[COORD_W-1:0];
            end
            ST_REPLAY: begin
                // A zero-length path spends one REPLAY cycle with no valid.
                valid_out = (rep_idx_q < path_len_q);
                dir_out   = valid_out ? rd_dir : DIR_R;
            end
            default: ;
        endcase
    end

    assign bus.X          = x_out;
    assign bus.Y          = y_out;
    assign bus.RD         = rd_out;
    assign bus.WR         = wr_out;
    assign bus.Din        = wr_out;
    assign bus.move_valid = valid_out;
    assign bus.move_dir   = dir_out;

    assign busy     = !idle_like;
    assign done     = (state_q == ST_DONE);
    assign fail     = (state_q == ST_FAIL);
    assign path_len = path_len_q;

endmodule

// File: tb/tb_rat_navigator.sv
// -----------------------------------------------------------------------------
// tb_rat_navigator
// Self-checking bench for rat_navigator: a 16x16 maze memory model, a
// depth-first reference solver working on plain arrays and queues, a table of
// hand-derived scenarios, random mazes, reset-mid-solve and start-while-busy.
// -----------------------------------------------------------------------------
module tb_rat_navigator;
    import rat_navigator_pkg::*;

    typedef bit [15:0] maze_t [16];  // maze[y][x], 1 = wall/visited
    typedef enum int {K_EMPTY, K_CORNER, K_DEAD_END, K_ENCLOSED} kind_e;
    typedef struct {
        kind_e kind;
        int    exp_fail;
        int    exp_len;
        int    exp_cycles;  // edges from INIT to REPLAY/FAIL entry, -1 = n/a
        int    exp_pops;    // -1 = n/a
        int    exp_first;   // first move_dir, -1 = n/a
        int    exp_zeros;   // free cells left in memory afterwards
    } vec_t;

    localparam int MAX_CYC = 20000;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       busy, done, fail;
    logic [8:0] path_len;

    rat_navigator_if bus ();

    rat_navigator dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .bus      (bus),
        .busy     (busy),
        .done     (done),
        .fail     (fail),
        .path_len (path_len)
    );

    always #5 clk = ~clk;

    // ------------------------------------------------------ maze memory model
    maze_t mem;
    maze_t load_img;
    logic  load_req    = 1'b0;
    int    bus_err_cnt = 0;

    assign bus.Dout = bus.RD ? mem[bus.Y][bus.X] : 1'b0;

    always @(posedge clk) begin
        if (load_req) mem <= load_img;
        else if (bus.WR) mem[bus.Y][bus.X] <= bus.Din;
    end

    always @(posedge clk) begin
        if ((bus.RD && bus.WR) || (bus.WR && !bus.Din)) bus_err_cnt++;
    end

    // --------------------------------------------------------------- checking
    int vectors     = 0;
    int miscompares = 0;
    int dx [4] = '{1, 0, -1, 0};
    int dy [4] = '{0, 1, 0, -1};

    task automatic check(input string name, input int actual, input int expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // -------------------------------------------------------- reference model
    int         exp_fail, exp_cycles, exp_pops;
    int         exp_dirs [$];
    maze_t      exp_vis;

    function automatic bit is_free(input maze_t v, input int x, input int y);
        if (x < 0 || x > 15 || y < 0 || y > 15) return 1'b0;
        return !v[y][x];
    endfunction

    task automatic model_solve(input maze_t m);
        maze_t v;
        int    x, y;
        int    stk [$];
        v = m;
        v[0][0] = 1'b1;
        x = 0;
        y = 0;
        exp_cycles = 1;  // INIT
        exp_pops   = 0;
        exp_fail   = 0;
        forever begin
            int fd;
            fd = -1;
            for (int d = 0; d < 4; d++) begin
                exp_cycles++;
                if (is_free(v, x + dx[d], y + dy[d])) begin
                    fd = d;
                    break;
                end
            end
            if (fd >= 0) begin
                exp_cycles++;
                x = x + dx[fd];
                y = y + dy[fd];
                v[y][x] = 1'b1;
                stk.push_back(fd);
                if (x == 15 && y == 15) break;
            end else if (stk.size() == 0) begin
                exp_fail = 1;
                break;
            end else begin
                int b;
                b = stk.pop_back();
                exp_cycles++;
                exp_pops++;
                x = x - dx[b];
                y = y - dy[b];
            end
        end
        exp_dirs = stk;
        exp_vis  = v;
    endtask

    // ------------------------------------------------------------- stimulus
    int obs_dirs [$];
    int obs_cycles, obs_pops, obs_busy_init, obs_flags_init, timed_out, pulsed;

    function automatic maze_t build_maze(input kind_e k);
        maze_t m;
        for (int y = 0; y < 16; y++) m[y] = 16'h0000;
        case (k)
            K_CORNER: begin
                m[0][1] = 1'b1;
                m[1][0] = 1'b1;
            end
            K_DEAD_END: begin
                m[0][4] = 1'b1;
                m[1][1] = 1'b1;
                m[1][2] = 1'b1;
                m[1][3] = 1'b1;
            end
            K_ENCLOSED: begin
                m[15][14] = 1'b1;
                m[14][15] = 1'b1;
            end
            default: ;
        endcase
        return m;
    endfunction

    function automatic maze_t random_maze(input int density);
        maze_t m;
        for (int y = 0; y < 16; y++)
            for (int x = 0; x < 16; x++)
                m[y][x] = ($urandom_range(0, 99) < density);
        m[0][0]   = 1'b0;
        m[15][15] = 1'b0;
        return m;
    endfunction

    function automatic int count_zeros(input maze_t m);
        int n = 0;
        for (int y = 0; y < 16; y++)
            for (int x = 0; x < 16; x++)
                if (!m[y][x]) n++;
        return n;
    endfunction

    task automatic load_maze(input maze_t m);
        @(negedge clk);
        load_img = m;
        load_req = 1'b1;
        @(posedge clk);
        #1;
        load_req = 1'b0;
    endtask

    task automatic run_solve(input bit pulse_in_move);
        int n, m;
        obs_dirs.delete();
        obs_pops = 0;
        pulsed   = 0;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        obs_busy_init  = busy;
        obs_flags_init = done | fail;
        n = 0;
        while (!bus.move_valid && !fail && n < MAX_CYC) begin
            // WR after the INIT cycle can only be a MOVE cycle.
            if (pulse_in_move && !pulsed && n > 0 && bus.WR) begin
                start  = 1'b1;
                pulsed = 1;
            end
            @(posedge clk);
            #1;
            start = 1'b0;
            n++;
            if (dut.state_q == ST_POP) obs_pops++;
        end
        timed_out  = (n >= MAX_CYC);
        obs_cycles = n;
        m = 0;
        while (bus.move_valid && m < 300) begin
            obs_dirs.push_back(int'(bus.move_dir));
            @(posedge clk);
            #1;
            m++;
        end
    endtask

    task automatic check_run(input string tag, input maze_t orig);
        int exp_len, diffs, bad, x, y;
        exp_len = exp_fail ? 0 : exp_dirs.size();
        check({tag, "_timeout"},    timed_out, 0);
        check({tag, "_busy_init"},  obs_busy_init, 1);
        check({tag, "_flags_init"}, obs_flags_init, 0);
        check({tag, "_fail"},       fail, exp_fail);
        check({tag, "_done"},       done, !exp_fail);
        check({tag, "_busy_end"},   busy, 0);
        check({tag, "_path_len"},   path_len, exp_len);
        check({tag, "_stream_len"}, obs_dirs.size(), exp_len);
        check({tag, "_cycles"},     obs_cycles, exp_cycles);
        check({tag, "_pops"},       obs_pops, exp_pops);
        check({tag, "_sp_end"},     dut.u_path_stack.sp, exp_len);
        diffs = 0;
        for (int i = 0; i < exp_len && i < obs_dirs.size(); i++)
            if (obs_dirs[i] != exp_dirs[i]) diffs++;
        check({tag, "_dir_diffs"}, diffs, 0);
        diffs = 0;
        for (int yy = 0; yy < 16; yy++)
            for (int xx = 0; xx < 16; xx++)
                if (mem[yy][xx] != exp_vis[yy][xx]) diffs++;
        check({tag, "_mem_diffs"}, diffs, 0);
        // Replayed path must walk only over free cells of the original map.
        bad = 0;
        x = 0;
        y = 0;
        foreach (obs_dirs[i]) begin
            x = x + dx[obs_dirs[i]];
            y = y + dy[obs_dirs[i]];
            if (!is_free(orig, x, y)) bad++;
        end
        check({tag, "_path_legal"}, bad, 0);
        if (!exp_fail) check({tag, "_path_end"}, (x == 15) && (y == 15), 1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"},       busy, 0);
        check({tag, "_done"},       done, 0);
        check({tag, "_fail"},       fail, 0);
        check({tag, "_rd_wr_din"},  {bus.RD, bus.WR, bus.Din}, 0);
        check({tag, "_xy"},         {bus.X, bus.Y}, 0);
        check({tag, "_move_valid"}, bus.move_valid, 0);
        check({tag, "_move_dir"},   bus.move_dir, 0);
        check({tag, "_path_len"},   path_len, 0);
        check({tag, "_sp"},         dut.u_path_stack.sp, 0);
    endtask

    // ------------------------------------------------------------------ test
    initial begin
        vec_t  vecs [4];
        maze_t m;
        int    found;

        vecs[0] = '{K_EMPTY,    0, 30, 76, 0, 0, 225};
        vecs[1] = '{K_CORNER,   1,  0,  5, 0, -1, 253};
        vecs[2] = '{K_DEAD_END, 0, 30, 97, 3, 1, 218};
        vecs[3] = '{K_ENCLOSED, 1,  0, -1, -1, -1, 1};

        rst   = 1'b0;
        start = 1'b0;
        #13;
        check_reset_outputs("reset");
        rst = 1'b1;

        foreach (vecs[i]) begin
            string tag;
            tag = $sformatf("vec%0d", i);
            m = build_maze(vecs[i].kind);
            model_solve(m);
            load_maze(m);
            run_solve(1'b0);
            check_run(tag, m);
            check({tag, "_tbl_fail"}, fail, vecs[i].exp_fail);
            check({tag, "_tbl_len"},  path_len, vecs[i].exp_len);
            check({tag, "_tbl_zeros"}, count_zeros(mem), vecs[i].exp_zeros);
            if (vecs[i].exp_cycles >= 0) check({tag, "_tbl_cycles"}, obs_cycles, vecs[i].exp_cycles);
            if (vecs[i].exp_pops >= 0)   check({tag, "_tbl_pops"},   obs_pops,   vecs[i].exp_pops);
            if (vecs[i].exp_first >= 0)
                check({tag, "_tbl_first"}, (obs_dirs.size() > 0) ? obs_dirs[0] : -1, vecs[i].exp_first);
        end
        check("enclosed_goal_free", mem[15][15], 0);

        // Start pulsed during a MOVE cycle must not perturb the solve.
        m = build_maze(K_DEAD_END);
        model_solve(m);
        load_maze(m);
        run_solve(1'b1);
        check("busy_start_pulsed", pulsed, 1);
        check_run("busy_start", m);

        // Asynchronous reset in the middle of a PROBE cycle.
        m = build_maze(K_EMPTY);
        load_maze(m);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        found = 0;
        for (int n = 0; n < 100 && !found; n++) begin
            @(posedge clk);
            #1;
            if (bus.RD && bus.X >= 4'd3) found = 1;
        end
        check("rst_mid_probe_seen", found, 1);
        #2;
        rst = 1'b0;
        #1;
        check_reset_outputs("rst_mid");
        #3;
        rst = 1'b1;
        model_solve(m);
        load_maze(m);
        run_solve(1'b0);
        check_run("after_rst", m);

        // Random mazes against the reference solver.
        for (int r = 0; r < 8; r++) begin
            m = random_maze(20 + 2 * r);
            model_solve(m);
            load_maze(m);
            run_solve(1'b0);
            check_run($sformatf("rand%0d", r), m);
        end

        check("bus_protocol", bus_err_cnt, 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/rat_navigator.md
# rat_navigator

Depth-first maze-solving controller for the 16x16 maze memory. On `start` it walks from (0,0) to (15,15) by driving the memory's X/Y/RD/WR/Din port, marks every entered cell as visited by writing 1, and records each move on an internal direction stack. It backtracks on dead ends. On success it streams the recorded path to the downstream consumer, one move per cycle. On exhaustion it reports failure.

## Interface
Parameters:
- `GOAL_X`, default 15: goal column.
- `GOAL_Y`, default 15: goal row.
- `DEPTH`, default 256: stack entries; must be ≥ number of maze cells.

Ports:
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  asynchronous, active-low reset.
- `start`  in  1  single-cycle request to begin a solve.
- `Dout`  in  1  maze cell value: 1 = wall or visited, 0 = free. Combinational from X/Y while RD=1.
- `X`, `Y`  out  4 each  cell address; X = column, Y = row.
- `RD`  out  1  read strobe.
- `WR`  out  1  write strobe; the memory writes Din at the clk edge.
- `Din`  out  1  write data; always 1 when WR=1.
- `busy`  out  1  solve or replay in progress.
- `done`  out  1  path found and fully streamed; held until next start.
- `fail`  out  1  no path exists; held until next start.
- `move_valid`  out  1  one path step is valid this cycle.
- `move_dir`  out  2  step direction: 00 right (X+1), 01 down (Y+1), 10 left (X-1), 11 up (Y-1).
- `path_len`  out  9  number of moves in the final path.

## Operation
- **States:** IDLE, INIT, PROBE, MOVE, POP, REPLAY, DONE, FAIL.
- **IDLE, DONE, FAIL:** `start`=1 goes to INIT. The block clears position to (0,0), sets stack pointer to 0, direction counter `d` to 0, and clears `done`/`fail`. In all other states `start` is ignored.
- **INIT:** one cycle. WR=1 at (0,0) marks the start cell visited. Next state is PROBE.
- **PROBE:** one cycle per direction `d`.
  - Neighbour out of bounds: RD=0 and the cell counts as blocked.
  - Otherwise RD=1 with X/Y set to the neighbour, and Dout is sampled at the edge.
  - Free neighbour: go to MOVE.
  - Blocked and `d`<3: increment `d` and stay in PROBE.
  - Blocked and `d`=3: go to POP if sp>0, else FAIL.
- **MOVE:** one cycle.
  - WR=1 at the neighbour.
  - Push `d`, step position, reset `d` to 0.
  - If the new position is the goal, `path_len`←sp+1 and go to REPLAY; otherwise go to PROBE.
- **POP:** one cycle. Pop the top direction, step the position opposite to it, reset `d` to 0, go to PROBE. Re-probing is safe because visited cells read 1.
- **REPLAY:** read stack entries 0..path_len-1 in order. Each cycle drives `move_valid`=1 with `move_dir` set to the entry. After the last entry go to DONE.
- **DONE/FAIL:** hold flags; `busy`=0. Visited marks stay in the memory, so the maze must be reloaded externally before a meaningful re-solve.
- **Arithmetic:**
  - Neighbour coordinates are computed in 5 bits so that 15+1 and 0-1 are flagged out of bounds, never wrapped.
  - The stack pointer is 9 bits. Push at sp=DEPTH is impossible by construction; the implementation asserts in simulation if it occurs.
- **Goal equal to start:** INIT goes directly to REPLAY with `path_len`=0, then to DONE.

## Timing
- **Reset values:** state IDLE; X=Y=0; RD=WR=Din=0; busy=done=fail=move_valid=0; move_dir=0; path_len=0; sp=0.
- **Reset mid-operation:** abandons immediately to IDLE. Memory contents are not restored by this block.
- RD and WR are never asserted in the same cycle. Outside PROBE/INIT/MOVE both are 0 and X/Y hold their last value.
- **Flag timing:**
  - `busy` rises the cycle after `start` is sampled and falls in the cycle DONE or FAIL is entered.
  - `done`/`fail` rise on that same edge.
- **Cycle costs:** one cycle per probe, per move and per pop. REPLAY takes exactly `path_len` cycles, with no gaps in `move_valid`.

## Structure
- Shared package holds the direction encoding constants (DIR_R/D/L/U), the state enum, and the maze dimension constant (16).
- One sub-module, `path_stack`: DEPTH×2-bit register file with push/pop, a sp output, and an independent indexed read port for REPLAY.

## Test plan
- **Empty maze (all 0):** expect path_len=30, 15× move_dir=00 then 15× 01, done=1, fail=0, 76 cycles from INIT to REPLAY entry.
- **Walls at (1,0) and (0,1):** expect fail=1 after INIT + 4 probes, path_len=0, no move_valid pulses.
- **Dead end:** corridor right to (3,0), walled below it, with the only route down column 0. Expect 3 POP cycles, then a final path starting with 01, and every replayed step landing on a 0 cell of the original map.
- **Fully enclosed goal:** walls at (14,15) and (15,14) on an otherwise empty map. Expect fail=1, every reachable cell written to 1, and sp=0 at FAIL.
- **Reset mid-solve:** drop `rst` during PROBE. Expect all outputs at reset values asynchronously; a subsequent start on a reloaded maze solves normally.
- **Start while busy:** pulse `start` during MOVE. Expect no effect on state, sp or path; the result is identical to the unpulsed run.
